// File: rtl/log2_norm_pipe.sv
// log2_norm_pipe: three-stage valid/ready pipeline giving MSB index, normalised mantissa and Mitchell log2 of each sample.
//   clk, reset (async, active-high)
//   in_valid/in_ready/data_in/ch_in : input handshake, sample and channel tag
//   out_valid/out_ready             : output handshake
//   int_part/mant/log2_val/ch_out/zero_flag : result of the sample leaving stage 3
//   clamp_clr/clamp_cnt             : saturating count of zero samples replaced by MIN_THRESHOLD
module log2_norm_pipe #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_WIDTH    = 8,
  parameter int MIN_THRESHOLD = 1,
  parameter int CH_WIDTH      = 2,
  parameter int CNT_WIDTH     = 16,
  parameter int SHIFT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic [CH_WIDTH-1:0]               ch_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SHIFT_WIDTH-1:0]            int_part,
  output logic [FRAC_WIDTH:0]               mant,
  output logic [SHIFT_WIDTH+FRAC_WIDTH-1:0] log2_val,
  output logic [CH_WIDTH-1:0]               ch_out,
  output logic                              zero_flag,
  input  logic                              clamp_clr,
  output logic [CNT_WIDTH-1:0]              clamp_cnt
);
  localparam logic [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(MIN_THRESHOLD);
  logic                   s1_v, s2_v, s2_en, s3_en, zero_in;
  logic [DATA_WIDTH-1:0]  s1_d, norm;
  logic [CH_WIDTH-1:0]    s1_c, s2_c;
  logic                   s1_z, s2_z;
  logic [SHIFT_WIDTH-1:0] msb, sh, s2_m;
  logic [FRAC_WIDTH-1:0]  frac, s2_f;
  // each stage loads when empty or when its occupant moves on, so bubbles collapse
  assign s3_en    = !out_valid || out_ready;
  assign s2_en    = !s2_v || s3_en;
  assign in_ready = !s1_v || s2_en;
  assign zero_in  = data_in == '0;
  assign log2_val = {int_part, mant[FRAC_WIDTH-1:0]};
  always_comb begin
    msb = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (s1_d[i]) msb = SHIFT_WIDTH'(i);
    sh   = SHIFT_WIDTH'(DATA_WIDTH - 1) - msb;
    norm = s1_d << sh;
    frac = FRAC_WIDTH'(norm >> (DATA_WIDTH - 1 - FRAC_WIDTH));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_v      <= 1'b0;
      s1_d      <= '0;
      s1_c      <= '0;
      s1_z      <= 1'b0;
      s2_v      <= 1'b0;
      s2_m      <= '0;
      s2_f      <= '0;
      s2_c      <= '0;
      s2_z      <= 1'b0;
      out_valid <= 1'b0;
      int_part  <= '0;
      mant      <= '0;
      ch_out    <= '0;
      zero_flag <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        s1_d <= zero_in ? MIN_V : data_in;
        s1_c <= ch_in;
        s1_z <= zero_in;
      end
      if (s2_en) begin
        s2_v <= s1_v;
        s2_m <= msb;
        s2_f <= frac;
        s2_c <= s1_c;
        s2_z <= s1_z;
      end
      if (s3_en) begin
        out_valid <= s2_v;
        int_part  <= s2_m;
        mant      <= {1'b1, s2_f};
        ch_out    <= s2_c;
        zero_flag <= s2_z;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) clamp_cnt <= '0;
    else if (clamp_clr) clamp_cnt <= '0;
    else if (in_valid && in_ready && zero_in && clamp_cnt != '1) clamp_cnt <= clamp_cnt + CNT_WIDTH'(1);
endmodule
